// File: rtl/sort4_stream.sv
// Word-serial 4-entry descending sorter: load 4 words, 4 odd-even transposition phases, emit.
// Optional SORT4_TAG_EN adds out_tag carrying each word's original input position.
module sort4_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_cnt
`ifdef SORT4_TAG_EN
  ,
  output logic [1:0]       out_tag
`endif
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       wr_idx_q, wr_idx_d;
  logic [1:0]       rd_idx_q, rd_idx_d;
  logic [1:0]       phase_q, phase_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [WIDTH-1:0] buf_q [4];
  logic [WIDTH-1:0] buf_d [4];
`ifdef SORT4_TAG_EN
  logic [1:0]       tag_q [4];
  logic [1:0]       tag_d [4];
`endif

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    phase_d     = phase_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;
    for (int i = 0; i < 4; i++) begin
      buf_d[i] = buf_q[i];
`ifdef SORT4_TAG_EN
      tag_d[i] = tag_q[i];
`endif
    end

    // flush outranks every handshake on the same edge, including the last-word one
    if (flush) begin
      state_d     = ST_LOAD;
      wr_idx_d    = 2'd0;
      rd_idx_d    = 2'd0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          in_ready_d = 1'b1;
          if (in_valid && in_ready_q) begin
            buf_d[wr_idx_q] = in_data;
`ifdef SORT4_TAG_EN
            tag_d[wr_idx_q] = wr_idx_q;
`endif
            if (wr_idx_q == 2'd3) begin
              in_ready_d = 1'b0;
              wr_idx_d   = 2'd0;
              phase_d    = 2'd0;
              state_d    = ST_SORT;
            end else begin
              wr_idx_d = wr_idx_q + 2'd1;
            end
          end
        end
        ST_SORT: begin
          // even phases touch pairs (0,1),(2,3); odd phases touch (1,2); strict < keeps ties stable
          for (int i = 0; i < 3; i++) begin
            if ((i[0] == phase_q[0]) && (buf_q[i] < buf_q[i+1])) begin
              buf_d[i]   = buf_q[i+1];
              buf_d[i+1] = buf_q[i];
`ifdef SORT4_TAG_EN
              tag_d[i]   = tag_q[i+1];
              tag_d[i+1] = tag_q[i];
`endif
            end
          end
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            state_d     = ST_EMIT;
            out_valid_d = 1'b1;
            rd_idx_d    = 2'd0;
          end
        end
        ST_EMIT: begin
          if (out_valid_q && out_ready) begin
            rd_idx_d = rd_idx_q + 2'd1;
            if (rd_idx_q == 2'd3) begin
              out_valid_d = 1'b0;
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
              in_ready_d  = 1'b1;
              state_d     = ST_LOAD;
            end
          end
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      wr_idx_q    <= 2'd0;
      rd_idx_q    <= 2'd0;
      phase_q     <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
`ifdef SORT4_TAG_EN
        tag_q[i] <= 2'd0;
`endif
      end
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      phase_q     <= phase_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= buf_d[i];
`ifdef SORT4_TAG_EN
        tag_q[i] <= tag_d[i];
`endif
      end
    end
  end

  // Outputs decode straight from registers, so they stay stable under backpressure
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? buf_q[rd_idx_q] : '0;
  assign out_last  = out_valid_q && (rd_idx_q == 2'd3);
  assign frame_cnt = frame_cnt_q;
`ifdef SORT4_TAG_EN
  assign out_tag   = out_valid_q ? tag_q[rd_idx_q] : 2'd0;
`endif

endmodule
